// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the state codes, opcode/funct constants, ALU_Op codes and datapath
// mux-select encodings. ALU_Control and the datapath use the same values.
// The package also holds the bundled control-word struct that the top-level
// output decode fills in.
package mips_ctrl_defs;

    // FSM state codes. They are visible on the State debug port, so the
    // numeric values are fixed.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct codes (IR[5:0]) of interest to the control path
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;

    // ALU_Op codes sent to ALU_Control
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU operand selects
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_A      = 1'b1;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // Memory address select
    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_ALUOUT = 1'b1;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // One control word for the whole datapath
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // States that wait on the memory handshake and so feed the watchdog
    function automatic logic is_mem_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_mc_next_state.sv
// Combinational next-state decode for the multi-cycle control FSM.
// Ports:
//   state_i      current FSM state
//   opcode_i     IR[31:26] (only meaningful from DECODE onward)
//   funct_i      IR[5:0]
//   mem_ready_i  memory completes the current access this cycle
//   timeout_i    watchdog expires this cycle (only raised in a memory-wait state)
//   next_state_o state to load on the next clock edge
module mips_mc_next_state
    import mips_ctrl_defs::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  state_t              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic                mem_ready_i,
    input  logic                timeout_i,
    output state_t              next_state_o
);

    always_comb begin
        next_state_o = state_i;
        case (state_i)
            // Memory-wait states: completion takes priority over the
            // watchdog. The watchdog cannot fire when Mem_Ready is high.
            S_FETCH: begin
                if (mem_ready_i)    next_state_o = S_DECODE;
                else if (timeout_i) next_state_o = S_TRAP;
            end
            S_MEM_READ: begin
                if (mem_ready_i)    next_state_o = S_MEM_WB;
                else if (timeout_i) next_state_o = S_TRAP;
            end
            S_MEM_WRITE: begin
                if (mem_ready_i)    next_state_o = S_FETCH;
                else if (timeout_i) next_state_o = S_TRAP;
            end
            S_DECODE: begin
                case (opcode_i)
                    OPCODE_W'(OP_RTYPE):
                        next_state_o = (funct_i == FUNCT_W'(FN_JR)) ? S_JR : S_R_EXEC;
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):   next_state_o = S_MEM_ADDR;
                    OPCODE_W'(OP_BEQ),
                    OPCODE_W'(OP_BNE):  next_state_o = S_BRANCH;
                    OPCODE_W'(OP_J):    next_state_o = S_JUMP;
                    OPCODE_W'(OP_JAL):  next_state_o = S_JAL;
                    OPCODE_W'(OP_ADDI),
                    OPCODE_W'(OP_ANDI),
                    OPCODE_W'(OP_ORI),
                    OPCODE_W'(OP_SLTI): next_state_o = S_I_EXEC;
                    default:            next_state_o = S_TRAP;
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so anything that is not sw is a load.
            S_MEM_ADDR:
                next_state_o = (opcode_i == OPCODE_W'(OP_SW)) ? S_MEM_WRITE : S_MEM_READ;
            S_R_EXEC: next_state_o = S_R_WB;
            S_I_EXEC: next_state_o = S_I_WB;
            S_MEM_WB,
            S_R_WB,
            S_I_WB,
            S_BRANCH,
            S_JUMP,
            S_JAL,
            S_JR:     next_state_o = S_FETCH;
            // TRAP is absorbing. The unused code 15 also lands there.
            default:  next_state_o = S_TRAP;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction
// over 3-5 cycles (plus memory wait cycles) through a shared ALU and a
// unified memory. A watchdog traps when memory stalls too long, and an
// undecodable opcode also traps.
// Ports:
//   Clock, reset           clock (rising edge) and async active-high reset
//   Opcode, Funct          IR fields
//   Mem_Ready              memory handshake: current access completes this cycle
//   PC_Write..PC_Source    datapath enables and mux selects
//   Instr_Done             pulse in the last cycle of each instruction
//   Fault                  sticky: 00 none, 01 illegal opcode, 10 memory timeout
//   State                  current state code (debug)
// All outputs are forced to 0 while reset is high.
module mips_multicycle_control
    import mips_ctrl_defs::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic                Clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Mem_Ready,
    output logic                PC_Write,
    output logic                PC_Write_Cond,
    output logic                PC_Write_Cond_NE,
    output logic                I_or_D,
    output logic                Mem_Read,
    output logic                Mem_Write,
    output logic                IR_Write,
    output logic                Reg_Write,
    output logic [1:0]          Reg_Dst,
    output logic [1:0]          Mem_to_Reg,
    output logic                ALU_Src_A,
    output logic [1:0]          ALU_Src_B,
    output logic [ALUOP_W-1:0]  ALU_Op,
    output logic [1:0]          PC_Source,
    output logic                Instr_Done,
    output logic [1:0]          Fault,
    output logic [3:0]          State
);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [1:0]      fault_q, fault_d;
    logic            mem_wait;
    logic            timeout_hit;
    ctrl_t           ctrl;

    // ---------------- watchdog ----------------
    // to_q counts the consecutive stalled cycles that came before this one.
    // The stall cycle that takes the count to TIMEOUT diverts the FSM to TRAP.
    always_comb begin
        mem_wait    = is_mem_wait_state(state_q) && !Mem_Ready;
        timeout_hit = mem_wait && (to_q == TO_W'(TIMEOUT - 1));
        // Any state change (completion or trap) clears the count.
        to_d        = (mem_wait && !timeout_hit) ? to_q + TO_W'(1) : '0;
    end

    mips_mc_next_state #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_next_state (
        .state_i      (state_q),
        .opcode_i     (Opcode),
        .funct_i      (Funct),
        .mem_ready_i  (Mem_Ready),
        .timeout_i    (timeout_hit),
        .next_state_o (state_d)
    );

    // Record the cause only on the transition into TRAP. Nothing leaves
    // TRAP except reset, so the code stays put afterwards.
    always_comb begin
        fault_d = fault_q;
        if (state_q != S_TRAP && state_d == S_TRAP)
            fault_d = timeout_hit ? FAULT_TIMEOUT : FAULT_ILLEGAL;
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            to_q    <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            fault_q <= fault_d;
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = IORD_PC;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC+4 are captured only in the cycle the fetch completes.
                ctrl.ir_write  = Mem_Ready;
                ctrl.pc_write  = Mem_Ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = IORD_ALUOUT;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = IORD_ALUOUT;
                ctrl.instr_done = Mem_Ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a        = SRCA_A;
                ctrl.alu_src_b        = SRCB_B;
                ctrl.alu_op           = ALU_SUB;
                ctrl.pc_source        = PCSRC_ALUOUT;
                ctrl.pc_write_cond    = (Opcode == OPCODE_W'(OP_BEQ));
                ctrl.pc_write_cond_ne = (Opcode == OPCODE_W'(OP_BNE));
                ctrl.instr_done       = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.instr_done = 1'b1;
            end
            S_JR: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_REG;
                ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                case (Opcode)
                    OPCODE_W'(OP_ANDI): ctrl.alu_op = ALU_AND;
                    OPCODE_W'(OP_ORI):  ctrl.alu_op = ALU_OR;
                    OPCODE_W'(OP_SLTI): ctrl.alu_op = ALU_SLT;
                    default:            ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;   // TRAP: everything quiet
        endcase
    end

    // Outputs are gated by reset, so an aborted access drops its strobes at once.
    assign PC_Write         = !reset && ctrl.pc_write;
    assign PC_Write_Cond    = !reset && ctrl.pc_write_cond;
    assign PC_Write_Cond_NE = !reset && ctrl.pc_write_cond_ne;
    assign I_or_D           = !reset && ctrl.i_or_d;
    assign Mem_Read         = !reset && ctrl.mem_read;
    assign Mem_Write        = !reset && ctrl.mem_write;
    assign IR_Write         = !reset && ctrl.ir_write;
    assign Reg_Write        = !reset && ctrl.reg_write;
    assign ALU_Src_A        = !reset && ctrl.alu_src_a;
    assign Instr_Done       = !reset && ctrl.instr_done;
    assign Reg_Dst          = reset ? 2'b00 : ctrl.reg_dst;
    assign Mem_to_Reg       = reset ? 2'b00 : ctrl.mem_to_reg;
    assign ALU_Src_B        = reset ? 2'b00 : ctrl.alu_src_b;
    assign ALU_Op           = reset ? '0 : ALUOP_W'(ctrl.alu_op);
    assign PC_Source        = reset ? 2'b00 : ctrl.pc_source;
    assign Fault            = reset ? FAULT_NONE : fault_q;
    assign State            = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control. Each cycle compares the
// state, the full control word and the fault code against constants that
// were worked out by hand.
module tb_mips_multicycle_control;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       Mem_Ready = 1'b0;
    logic       PC_Write, PC_Write_Cond, PC_Write_Cond_NE, I_or_D;
    logic       Mem_Read, Mem_Write, IR_Write, Reg_Write;
    logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Source, Fault;
    logic       ALU_Src_A, Instr_Done;
    logic [2:0] ALU_Op;
    logic [3:0] State;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int txn_start = 0;

    mips_multicycle_control dut (
        .Clock(Clock), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond),
        .PC_Write_Cond_NE(PC_Write_Cond_NE), .I_or_D(I_or_D), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
        .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .ALU_Src_A(ALU_Src_A),
        .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op), .PC_Source(PC_Source),
        .Instr_Done(Instr_Done), .Fault(Fault), .State(State)
    );

    always #5 Clock = ~Clock;

    // Control word layout:
    // {pcw, pcwc, pcwne, iord, mrd, mwr, irw, rw, reg_dst[2], mem_to_reg[2],
    //  src_a, src_b[2], alu_op[3], pc_source[2], done}
    logic [20:0] obs;
    assign obs = {PC_Write, PC_Write_Cond, PC_Write_Cond_NE, I_or_D, Mem_Read,
                  Mem_Write, IR_Write, Reg_Write, Reg_Dst, Mem_to_Reg,
                  ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source, Instr_Done};

    localparam logic [20:0] E_ZERO       = 21'd0;
    localparam logic [20:0] E_FETCH_WAIT = {8'b0000_1000, 4'b0000, 1'b0, 2'b01, 3'b000, 2'b00, 1'b0};
    localparam logic [20:0] E_FETCH_RDY  = {8'b1000_1010, 4'b0000, 1'b0, 2'b01, 3'b000, 2'b00, 1'b0};
    localparam logic [20:0] E_DECODE     = {8'b0000_0000, 4'b0000, 1'b0, 2'b11, 3'b000, 2'b00, 1'b0};
    localparam logic [20:0] E_MEM_ADDR   = {8'b0000_0000, 4'b0000, 1'b1, 2'b10, 3'b000, 2'b00, 1'b0};
    localparam logic [20:0] E_MEM_READ   = {8'b0001_1000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [20:0] E_MEM_WB     = {8'b0000_0001, 4'b0001, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1};
    localparam logic [20:0] E_MW_WAIT    = {8'b0001_0100, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [20:0] E_MW_RDY     = {8'b0001_0100, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1};
    localparam logic [20:0] E_R_EXEC     = {8'b0000_0000, 4'b0000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0};
    localparam logic [20:0] E_R_WB       = {8'b0000_0001, 4'b0100, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1};
    localparam logic [20:0] E_BEQ        = {8'b0100_0000, 4'b0000, 1'b1, 2'b00, 3'b001, 2'b01, 1'b1};
    localparam logic [20:0] E_BNE        = {8'b0010_0000, 4'b0000, 1'b1, 2'b00, 3'b001, 2'b01, 1'b1};
    localparam logic [20:0] E_JUMP       = {8'b1000_0000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b10, 1'b1};
    localparam logic [20:0] E_JAL        = {8'b1000_0001, 4'b1010, 1'b0, 2'b00, 3'b000, 2'b10, 1'b1};
    localparam logic [20:0] E_JR         = {8'b1000_0000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b11, 1'b1};
    localparam logic [20:0] E_I_OR       = {8'b0000_0000, 4'b0000, 1'b1, 2'b10, 3'b100, 2'b00, 1'b0};
    localparam logic [20:0] E_I_WB       = {8'b0000_0001, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1};

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive Mem_Ready, check the current cycle, then advance.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [20:0] ev, input logic [1:0] fl);
        Mem_Ready = rdy;
        #1;
        chk({tag, ".state"}, {28'd0, State}, {28'd0, st});
        chk({tag, ".ctrl"},  {11'd0, obs},   {11'd0, ev});
        chk({tag, ".fault"}, {30'd0, Fault}, {30'd0, fl});
        @(posedge Clock);
        #1;
        cyc_cnt++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".state"}, {28'd0, State}, 32'd0);
        chk({tag, ".ctrl"},  {11'd0, obs},   32'd0);
        chk({tag, ".fault"}, {30'd0, Fault}, 32'd0);
    endtask

    task automatic start_txn(input logic [5:0] op, input logic [5:0] fn);
        Opcode    = op;
        Funct     = fn;
        txn_start = cyc_cnt;
    endtask

    task automatic end_txn(input string name);
        $display("txn %s: %0d cycles", name, cyc_cnt - txn_start);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk_reset_outputs("reset_hold");
        @(posedge Clock);
        #1;
        reset = 1'b0;

        // ---- lw, zero-wait: 0,1,2,3,4 ----
        start_txn(6'h23, 6'h00);
        cyc("lw.fetch",  1'b1, 4'd0, E_FETCH_RDY, 2'b00);
        cyc("lw.decode", 1'b1, 4'd1, E_DECODE,    2'b00);
        cyc("lw.addr",   1'b1, 4'd2, E_MEM_ADDR,  2'b00);
        cyc("lw.read",   1'b1, 4'd3, E_MEM_READ,  2'b00);
        cyc("lw.wb",     1'b1, 4'd4, E_MEM_WB,    2'b00);
        end_txn("lw");

        // ---- add: 0,1,6,7 ----
        start_txn(6'h00, 6'h20);
        cyc("add.fetch",  1'b1, 4'd0, E_FETCH_RDY, 2'b00);
        cyc("add.decode", 1'b1, 4'd1, E_DECODE,    2'b00);
        cyc("add.exec",   1'b1, 4'd6, E_R_EXEC,    2'b00);
        cyc("add.wb",     1'b1, 4'd7, E_R_WB,      2'b00);
        end_txn("add");

        // ---- sw with 3 wait cycles in MEM_WRITE: 7 cycles ----
        start_txn(6'h2B, 6'h00);
        cyc("sw.fetch",  1'b1, 4'd0, E_FETCH_RDY, 2'b00);
        cyc("sw.decode", 1'b1, 4'd1, E_DECODE,    2'b00);
        cyc("sw.addr",   1'b1, 4'd2, E_MEM_ADDR,  2'b00);
        cyc("sw.wait1",  1'b0, 4'd5, E_MW_WAIT,   2'b00);
        cyc("sw.wait2",  1'b0, 4'd5, E_MW_WAIT,   2'b00);
        cyc("sw.wait3",  1'b0, 4'd5, E_MW_WAIT,   2'b00);
        cyc("sw.write",  1'b1, 4'd5, E_MW_RDY,    2'b00);
        end_txn("sw");

        // ---- beq / bne ----
        start_txn(6'h04, 6'h00);
        cyc("beq.fetch",  1'b1, 4'd0, E_FETCH_RDY, 2'b00);
        cyc("beq.decode", 1'b1, 4'd1, E_DECODE,    2'b00);
        cyc("beq.branch", 1'b1, 4'd8, E_BEQ,       2'b00);
        end_txn("beq");
        start_txn(6'h05, 6'h00);
        cyc("bne.fetch",  1'b1, 4'd0, E_FETCH_RDY, 2'b00);
        cyc("bne.decode", 1'b1, 4'd1, E_DECODE,    2'b00);
        cyc("bne.branch", 1'b1, 4'd8, E_BNE,       2'b00);
        end_txn("bne");

        // ---- ori ----
        start_txn(6'h0D, 6'h00);
        cyc("ori.fetch",  1'b1, 4'd0,  E_FETCH_RDY, 2'b00);
        cyc("ori.decode", 1'b1, 4'd1,  E_DECODE,    2'b00);
        cyc("ori.exec",   1'b1, 4'd10, E_I_OR,      2'b00);
        cyc("ori.wb",     1'b1, 4'd11, E_I_WB,      2'b00);
        end_txn("ori");

        // ---- j, jal, jr ----
        start_txn(6'h02, 6'h00);
        cyc("j.fetch",  1'b1, 4'd0, E_FETCH_RDY, 2'b00);
        cyc("j.decode", 1'b1, 4'd1, E_DECODE,    2'b00);
        cyc("j.jump",   1'b1, 4'd9, E_JUMP,      2'b00);
        end_txn("j");
        start_txn(6'h03, 6'h00);
        cyc("jal.fetch",  1'b1, 4'd0,  E_FETCH_RDY, 2'b00);
        cyc("jal.decode", 1'b1, 4'd1,  E_DECODE,    2'b00);
        cyc("jal.jal",    1'b1, 4'd12, E_JAL,       2'b00);
        end_txn("jal");
        start_txn(6'h00, 6'h08);
        cyc("jr.fetch",  1'b1, 4'd0,  E_FETCH_RDY, 2'b00);
        cyc("jr.decode", 1'b1, 4'd1,  E_DECODE,    2'b00);
        cyc("jr.jr",     1'b1, 4'd13, E_JR,        2'b00);
        end_txn("jr");

        // ---- lw with fetch waits, aborted by reset in MEM_READ ----
        start_txn(6'h23, 6'h00);
        cyc("lw2.fwait1", 1'b0, 4'd0, E_FETCH_WAIT, 2'b00);
        cyc("lw2.fwait2", 1'b0, 4'd0, E_FETCH_WAIT, 2'b00);
        cyc("lw2.fetch",  1'b1, 4'd0, E_FETCH_RDY,  2'b00);
        cyc("lw2.decode", 1'b1, 4'd1, E_DECODE,     2'b00);
        cyc("lw2.addr",   1'b1, 4'd2, E_MEM_ADDR,   2'b00);
        Mem_Ready = 1'b0;
        #1;
        chk("lw2.read_before_reset", {28'd0, State}, 32'd3);
        reset = 1'b1;
        #1;
        chk_reset_outputs("lw2.abort");
        @(posedge Clock);
        #1;
        reset = 1'b0;
        end_txn("lw2_aborted");
        cyc("post_abort.fetch", 1'b0, 4'd0, E_FETCH_WAIT, 2'b00);

        // ---- illegal opcode: TRAP with sticky Fault=01 ----
        start_txn(6'h3F, 6'h00);
        cyc("ill.fetch",  1'b1, 4'd0,  E_FETCH_RDY, 2'b00);
        cyc("ill.decode", 1'b1, 4'd1,  E_DECODE,    2'b00);
        cyc("ill.trap1",  1'b1, 4'd14, E_ZERO,      2'b01);
        cyc("ill.trap2",  1'b0, 4'd14, E_ZERO,      2'b01);
        cyc("ill.trap3",  1'b1, 4'd14, E_ZERO,      2'b01);
        end_txn("illegal");
        reset = 1'b1;
        #1;
        chk_reset_outputs("ill.reset");
        @(posedge Clock);
        #1;
        reset = 1'b0;

        // ---- fetch timeout: 16 stalled cycles, then TRAP with Fault=10 ----
        start_txn(6'h00, 6'h20);
        for (int i = 0; i < 16; i++)
            cyc($sformatf("to.wait%0d", i), 1'b0, 4'd0, E_FETCH_WAIT, 2'b00);
        cyc("to.trap1", 1'b1, 4'd14, E_ZERO, 2'b10);
        cyc("to.trap2", 1'b1, 4'd14, E_ZERO, 2'b10);
        end_txn("timeout");
        reset = 1'b1;
        #1;
        chk_reset_outputs("to.reset");
        @(posedge Clock);
        #1;
        reset = 1'b0;
        cyc("recover.fetch", 1'b0, 4'd0, E_FETCH_WAIT, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
